// File: rtl/instr_sequencer.sv
// Program-buffer sequencer in front of the processor's iin/resetn ports.
// It holds the processor in reset for one cycle, then issues buf[0..len-1], one slot per word.
module instr_sequencer #(
    parameter int IW          = 16,
    parameter int AW          = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          halt_req,
    input  logic          proc_done,
    output logic [IW-1:0] iin,
    output logic          proc_resetn,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          finished,
    output logic          aborted,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RSTP = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] MAX_LEN   = (AW + 1)'(DEPTH);
    localparam logic [7:0]  LAST_SLOT = 8'(HOLD_CYCLES - 1);

    logic [IW-1:0] buf_q [DEPTH];
    logic          buf_we;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_next;
    logic [7:0]    slot_q, slot_d;
    logic [IW-1:0] iin_q, iin_d;
    logic          proc_resetn_q, proc_resetn_d;
    logic          busy_q, busy_d;
    logic          finished_q, finished_d;
    logic          aborted_q, aborted_d;
    logic          slot_end;
    logic          last_instr;

    // Buffer has no reset so a program survives a processor/sequencer reset.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        pc_d          = pc_q;
        slot_d        = slot_q;
        iin_d         = iin_q;
        proc_resetn_d = proc_resetn_q;
        finished_d    = finished_q;
        aborted_d     = aborted_q;
        buf_we        = load_en && !busy_q;
        pc_next       = pc_q + 1'b1;
        slot_end      = (slot_q == LAST_SLOT) || proc_done;
        last_instr    = ({1'b0, pc_q} == (len_q - 1'b1));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (prog_len != '0) begin
                        len_d         = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                        pc_d          = '0;
                        finished_d    = 1'b0;
                        aborted_d     = 1'b0;
                        proc_resetn_d = 1'b0;
                        iin_d         = '0;
                        state_d       = S_RSTP;
                    end else begin
                        finished_d = 1'b1;
                        aborted_d  = 1'b0;
                        state_d    = S_DONE;
                    end
                end
            end
            S_RSTP: begin
                proc_resetn_d = 1'b1;
                if (halt_req) begin
                    iin_d      = '0;
                    finished_d = 1'b1;
                    aborted_d  = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    // A load in the start cycle has already landed, so buf[0] is current.
                    iin_d   = buf_q[0];
                    slot_d  = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                slot_d = slot_q + 8'd1;
                if (halt_req) begin
                    iin_d      = '0;
                    finished_d = 1'b1;
                    aborted_d  = 1'b1;
                    state_d    = S_DONE;
                end else if (slot_end) begin
                    if (last_instr) begin
                        iin_d      = '0;
                        finished_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        pc_d   = pc_next;
                        iin_d  = buf_q[pc_next];
                        slot_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RSTP) || (state_d == S_EXEC);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            pc_q          <= '0;
            slot_q        <= '0;
            iin_q         <= '0;
            proc_resetn_q <= 1'b1;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            pc_q          <= pc_d;
            slot_q        <= slot_d;
            iin_q         <= iin_d;
            proc_resetn_q <= proc_resetn_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
            aborted_q     <= aborted_d;
        end
    end

    assign iin         = iin_q;
    assign proc_resetn = proc_resetn_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign aborted     = aborted_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-cycle iin expectations are queued from a local
// copy of the program buffer and popped while the sequencer runs.
module tb_instr_sequencer;

    localparam int IW   = 16;
    localparam int AW   = 4;
    localparam int HOLD = 4;

    logic          clock;
    logic          resetn;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          halt_req;
    logic          proc_done;
    logic [IW-1:0] iin;
    logic          proc_resetn;
    logic [AW-1:0] pc;
    logic          busy;
    logic          finished;
    logic          aborted;
    logic [1:0]    dbg_state;

    logic [IW-1:0] model_mem [16];
    logic [IW-1:0] exp_q [$];
    int            total;
    int            bad;

    instr_sequencer #(.IW(IW), .AW(AW), .HOLD_CYCLES(HOLD)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .halt_req    (halt_req),
        .proc_done   (proc_done),
        .iin         (iin),
        .proc_resetn (proc_resetn),
        .pc          (pc),
        .busy        (busy),
        .finished    (finished),
        .aborted     (aborted),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // driver tasks
    task automatic load_word(input int addr, input logic [IW-1:0] data);
        load_en   = 1'b1;
        load_addr = addr[AW-1:0];
        load_data = data;
        tick();
        load_en = 1'b0;
        model_mem[addr] = data;
    endtask

    // Runs a program and checks every cycle. halt_at >= 0 raises halt_req in the
    // 2nd cycle of that slot; poke writes buf[3]=FFFF during the run (must be ignored).
    task automatic run_prog(input int len, input bit done_mode, input int halt_at, input bit poke);
        int            eff;
        int            hold;
        bit            halted;
        logic [IW-1:0] w;
        eff  = (len > 16) ? 16 : len;
        hold = done_mode ? 2 : HOLD;
        for (int i = 0; i < eff; i++)
            for (int k = 0; k < hold; k++)
                exp_q.push_back(model_mem[i]);

        prog_len = len[AW:0];
        start    = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        total++;
        if (proc_resetn !== 1'b0 || iin !== '0 || busy !== 1'b1 || finished !== 1'b0 || aborted !== 1'b0) begin
            bad++;
            $display("FAIL rstp: proc_resetn=%b iin=%h busy=%b finished=%b aborted=%b, want 0 0000 1 0 0",
                     proc_resetn, iin, busy, finished, aborted);
        end
        tick();

        halted = 1'b0;
        for (int i = 0; i < eff && !halted; i++) begin
            for (int k = 0; k < hold && !halted; k++) begin
                w = exp_q.pop_front();
                total++;
                if (iin !== w || pc !== 4'(i) || proc_resetn !== 1'b1 || busy !== 1'b1 || finished !== 1'b0) begin
                    bad++;
                    $display("FAIL exec[%0d.%0d]: iin=%h pc=%0d rn=%b busy=%b fin=%b, want iin=%h pc=%0d rn=1 busy=1 fin=0",
                             i, k, iin, pc, proc_resetn, busy, finished, w, i);
                end
                if (i == halt_at && k == 1) begin
                    halt_req = 1'b1;
                    tick();
                    halt_req = 1'b0;
                    halted   = 1'b1;
                end else begin
                    proc_done = done_mode && (k == 1);
                    load_en   = poke && (i == 1) && (k == 0);
                    load_addr = 4'd3;
                    load_data = 16'hFFFF;
                    tick();
                    proc_done = 1'b0;
                    load_en   = 1'b0;
                end
            end
        end

        total++;
        if (halted) begin
            if (iin !== '0 || finished !== 1'b1 || aborted !== 1'b1 || pc !== 4'(halt_at) || busy !== 1'b0) begin
                bad++;
                $display("FAIL halt_end: iin=%h fin=%b abort=%b pc=%0d busy=%b, want 0000 1 1 %0d 0",
                         iin, finished, aborted, pc, busy, halt_at);
            end
            exp_q.delete();
        end else begin
            if (iin !== '0 || finished !== 1'b1 || aborted !== 1'b0 || pc !== 4'(eff - 1) ||
                busy !== 1'b0 || exp_q.size() != 0) begin
                bad++;
                $display("FAIL run_end: iin=%h fin=%b abort=%b pc=%0d busy=%b left=%0d, want 0000 1 0 %0d 0 0",
                         iin, finished, aborted, pc, busy, exp_q.size(), eff - 1);
            end
        end
    endtask

    // scenarios
    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        total++;
        if (iin !== '0 || pc !== '0 || busy !== 1'b0 || finished !== 1'b0 || aborted !== 1'b0 ||
            proc_resetn !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset: iin=%h pc=%0d busy=%b fin=%b abort=%b rn=%b st=%0d, want 0000 0 0 0 0 1 0",
                     iin, pc, busy, finished, aborted, proc_resetn, dbg_state);
        end
    endtask

    task automatic test_basic();
        load_word(0, 16'hA40A);
        load_word(1, 16'hA805);
        load_word(2, 16'h0120);
        load_word(3, 16'h8000);
        run_prog(4, 1'b0, -1, 1'b0);
        tick();
        tick();
        total++;
        if (finished !== 1'b1 || iin !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_hold: fin=%b iin=%h busy=%b, want 1 0000 0", finished, iin, busy);
        end
    endtask

    task automatic test_proc_done();
        run_prog(4, 1'b1, -1, 1'b0);
    endtask

    task automatic test_halt();
        run_prog(4, 1'b0, 2, 1'b0);
        run_prog(4, 1'b0, -1, 1'b0);
    endtask

    task automatic test_zero_len();
        prog_len = '0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (finished !== 1'b1 || aborted !== 1'b0 || proc_resetn !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: fin=%b abort=%b rn=%b busy=%b, want 1 0 1 0",
                     finished, aborted, proc_resetn, busy);
        end
        tick();
        total++;
        if (proc_resetn !== 1'b1 || finished !== 1'b1) begin
            bad++;
            $display("FAIL zero_len_hold: rn=%b fin=%b, want 1 1", proc_resetn, finished);
        end
    endtask

    task automatic test_full_len();
        for (int a = 0; a < 16; a++)
            load_word(a, 16'($urandom_range(0, 65535)));
        run_prog(16, 1'b0, -1, 1'b0);
        run_prog(31, 1'b1, -1, 1'b0);
    endtask

    task automatic test_load_during_exec();
        run_prog(4, 1'b0, -1, 1'b1);
    endtask

    task automatic test_load_with_start();
        model_mem[0] = 16'h5A5A;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 16'h5A5A;
        run_prog(2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        prog_len = 5'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        total++;
        if (iin !== '0 || pc !== '0 || busy !== 1'b0 || finished !== 1'b0 || aborted !== 1'b0 ||
            proc_resetn !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: iin=%h pc=%0d busy=%b fin=%b abort=%b rn=%b, want 0000 0 0 0 0 1",
                     iin, pc, busy, finished, aborted, proc_resetn);
        end
        run_prog(4, 1'b0, -1, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        resetn    = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        prog_len  = '0;
        start     = 1'b0;
        halt_req  = 1'b0;
        proc_done = 1'b0;
        for (int a = 0; a < 16; a++) model_mem[a] = '0;

        test_reset();
        // Buffer has no reset; define it before any run depends on it.
        for (int a = 0; a < 16; a++) load_word(a, 16'h0000);
        test_basic();
        test_proc_done();
        test_halt();
        test_zero_len();
        test_load_during_exec();
        test_load_with_start();
        test_reset_mid_run();
        test_full_len();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
